// File: rtl/apb2_fifo_slave_pkg.sv
// Shared constants for the APB2 FIFO responder: register addresses, bit positions,
// and the decoded access type.
package apb2_fifo_slave_pkg;

    localparam int unsigned ADDR_TXDATA   = 0;
    localparam int unsigned ADDR_RXDATA   = 1;
    localparam int unsigned ADDR_STATUS   = 2;
    localparam int unsigned ADDR_CTRL     = 3;
    localparam int unsigned ADDR_TXCOUNT  = 4;
    localparam int unsigned ADDR_RXCOUNT  = 5;
    localparam int unsigned ADDR_IRQ_MASK = 6;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_TX_OVF   = 4;
    localparam int unsigned ST_RX_UDF   = 5;

    localparam int unsigned CTRL_TX_FLUSH = 0;
    localparam int unsigned CTRL_RX_FLUSH = 1;
    localparam int unsigned CTRL_TX_EN    = 2;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2
    } acc_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; head word is presented combinationally (no fall-through).
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_acc_c;
    logic             pop_acc_c;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign pop_acc_c  = pop && !empty;
    assign push_acc_c = push && (!full || pop_acc_c);
    assign rdata      = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH (power of two); flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_acc_c)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_acc_c, pop_acc_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc_c && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb2_fifo_slave.sv
// APB2 completer exposing TX/RX byte FIFOs plus status/control registers.
// Optional interrupt output and IRQ_MASK register: define APB2_FIFO_SLAVE_IRQ_EN.
module apb2_fifo_slave #(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [ADDR_BITS-1:0] PADDR,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [DATA_BITS-1:0] PWDATA,
    output logic [DATA_BITS-1:0] PRDATA,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
`ifdef APB2_FIFO_SLAVE_IRQ_EN
    output logic                 irq,
`endif
    output logic                 rx_ready
);

    import apb2_fifo_slave_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    acc_e                 acc_c;
    logic                 wr_c;
    logic                 rd_c;
    logic [CW-1:0]        tx_count;
    logic [CW-1:0]        rx_count;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 rx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic [DATA_BITS-1:0] rx_head;
    logic                 tx_push_c;
    logic                 tx_pop_c;
    logic                 tx_flush_c;
    logic                 rx_push_c;
    logic                 rx_pop_c;
    logic                 rx_flush_c;
    logic                 ctrl_wr_c;
    logic                 status_wr_c;
    logic                 tx_ovf_set_c;
    logic                 rx_udf_set_c;
    logic                 tx_ovf_q;
    logic                 rx_udf_q;
    logic                 tx_enable_q;
    logic [DATA_BITS-1:0] status_c;

    // Access phase decode; APB2 has no wait states so each commit is a single edge.
    always_comb begin
        acc_c = ACC_IDLE;
        if (PSEL && PENABLE) begin
            if (PWRITE) acc_c = ACC_WR;
            else        acc_c = ACC_RD;
        end
    end

    assign wr_c        = (acc_c == ACC_WR);
    assign rd_c        = (acc_c == ACC_RD);
    assign ctrl_wr_c   = wr_c && (PADDR == ADDR_BITS'(ADDR_CTRL));
    assign status_wr_c = wr_c && (PADDR == ADDR_BITS'(ADDR_STATUS));

    assign tx_push_c  = wr_c && (PADDR == ADDR_BITS'(ADDR_TXDATA));
    assign tx_pop_c   = tx_valid && tx_ready;
    assign tx_flush_c = ctrl_wr_c && PWDATA[CTRL_TX_FLUSH];
    assign rx_push_c  = rx_valid && rx_ready;
    assign rx_pop_c   = rd_c && (PADDR == ADDR_BITS'(ADDR_RXDATA));
    assign rx_flush_c = ctrl_wr_c && PWDATA[CTRL_RX_FLUSH];

    assign tx_ovf_set_c = tx_push_c && tx_full && !tx_pop_c && !tx_flush_c;
    assign rx_udf_set_c = rx_pop_c && rx_empty;

    assign tx_valid = !tx_empty && tx_enable_q;
    assign tx_data  = tx_head;
    assign rx_ready = !rx_full;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS), .CW(CW)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push_c),
        .pop   (tx_pop_c),
        .flush (tx_flush_c),
        .wdata (PWDATA),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS), .CW(CW)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_push_c),
        .pop   (rx_pop_c),
        .flush (rx_flush_c),
        .wdata (rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky error flags (set beats W1C clear) and the enable bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_ovf_q    <= 1'b0;
            rx_udf_q    <= 1'b0;
            tx_enable_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_set_c || (tx_ovf_q && !(status_wr_c && PWDATA[ST_TX_OVF]));
            rx_udf_q <= rx_udf_set_c || (rx_udf_q && !(status_wr_c && PWDATA[ST_RX_UDF]));
            if (ctrl_wr_c) tx_enable_q <= PWDATA[CTRL_TX_EN];
        end
    end

    always_comb begin
        status_c              = '0;
        status_c[ST_TX_FULL]  = tx_full;
        status_c[ST_TX_EMPTY] = tx_empty;
        status_c[ST_RX_FULL]  = rx_full;
        status_c[ST_RX_EMPTY] = rx_empty;
        status_c[ST_TX_OVF]   = tx_ovf_q;
        status_c[ST_RX_UDF]   = rx_udf_q;
    end

`ifdef APB2_FIFO_SLAVE_IRQ_EN
    logic [DATA_BITS-1:0] irq_mask_q;
    logic                 irq_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= |(status_c & irq_mask_q);
            if (wr_c && (PADDR == ADDR_BITS'(ADDR_IRQ_MASK))) irq_mask_q <= PWDATA;
        end
    end

    assign irq = irq_q;
`endif

    // Read data must be stable from the setup phase, so it decodes straight off PADDR.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_BITS'(ADDR_RXDATA):  PRDATA = rx_empty ? '0 : rx_head;
                ADDR_BITS'(ADDR_STATUS):  PRDATA = status_c;
                ADDR_BITS'(ADDR_CTRL):    PRDATA[CTRL_TX_EN] = tx_enable_q;
                ADDR_BITS'(ADDR_TXCOUNT): PRDATA = DATA_BITS'(tx_count);
                ADDR_BITS'(ADDR_RXCOUNT): PRDATA = DATA_BITS'(rx_count);
`ifdef APB2_FIFO_SLAVE_IRQ_EN
                ADDR_BITS'(ADDR_IRQ_MASK): PRDATA = irq_mask_q;
`endif
                default:                  PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb2_fifo_slave.sv
// Self-checking bench for apb2_fifo_slave: register table, directed corner sequences,
// then randomized APB + stream traffic against a queue-based reference model.
module tb_apb2_fifo_slave;

    localparam int unsigned DEPTH = 8;

    logic       PCLK    = 1'b0;
    logic       PRESETn = 1'b0;
    logic [3:0] PADDR   = 4'h0;
    logic       PSEL    = 1'b0;
    logic       PENABLE = 1'b0;
    logic       PWRITE  = 1'b0;
    logic [7:0] PWDATA  = 8'h00;
    logic [7:0] PRDATA;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
`ifdef APB2_FIFO_SLAVE_IRQ_EN
    logic       irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    apb2_fifo_slave #(.ADDR_BITS(4), .DATA_BITS(8), .DEPTH(DEPTH)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`ifdef APB2_FIFO_SLAVE_IRQ_EN
        .irq      (irq),
`endif
        .rx_ready (rx_ready)
    );

    always #5 PCLK = ~PCLK;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    // Tasks start and end just after a falling edge.
    task automatic apb_write(input logic [3:0] a, input logic [7:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK); PENABLE = 1'b1;
        @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [7:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA;
        @(negedge PCLK); PENABLE = 1'b1;
        @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic read_check(input string nm, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] d;
        apb_read(a, d);
        check8(nm, d, exp);
    endtask

    // Reference model: FIFOs as queues, registers as plain variables.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_ovf, m_udf, m_txen, m_irq;
    logic [7:0] m_mask;

    function automatic logic [7:0] m_status();
        logic [7:0] st;
        st    = 8'h00;
        st[0] = (tx_q.size() == DEPTH);
        st[1] = (tx_q.size() == 0);
        st[2] = (rx_q.size() == DEPTH);
        st[3] = (rx_q.size() == 0);
        st[4] = m_ovf;
        st[5] = m_udf;
        return st;
    endfunction

    function automatic logic [7:0] m_reg(input logic [3:0] a);
        case (a)
            4'h1: return (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            4'h2: return m_status();
            4'h3: return {5'b0, m_txen, 2'b00};
            4'h4: return 8'(tx_q.size());
            4'h5: return 8'(rx_q.size());
`ifdef APB2_FIFO_SLAVE_IRQ_EN
            4'h6: return m_mask;
`endif
            default: return 8'h00;
        endcase
    endfunction

    // Check outputs for the current inputs, then advance the model across the next rising edge.
    task automatic model_cycle();
        logic       exp_tv, exp_rr, wr, rd, ovf_set, udf_set;
        logic [7:0] st_pre;
        exp_tv = m_txen && (tx_q.size() != 0);
        exp_rr = (rx_q.size() < DEPTH);
        check1("rnd_tx_valid", tx_valid, exp_tv);
        if (exp_tv) check8("rnd_tx_data", tx_data, tx_q[0]);
        check1("rnd_rx_ready", rx_ready, exp_rr);
        check8("rnd_prdata", PRDATA, (PSEL && !PWRITE) ? m_reg(PADDR) : 8'h00);
`ifdef APB2_FIFO_SLAVE_IRQ_EN
        check1("rnd_irq", irq, m_irq);
`endif
        st_pre  = m_status();
        wr      = PSEL && PENABLE && PWRITE;
        rd      = PSEL && PENABLE && !PWRITE;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (exp_tv && tx_ready) void'(tx_q.pop_front());
        if (wr && PADDR == 4'h0) begin
            if (tx_q.size() < DEPTH) tx_q.push_back(PWDATA);
            else ovf_set = 1'b1;
        end
        if (wr && PADDR == 4'h3 && PWDATA[0]) tx_q.delete();
        if (rd && PADDR == 4'h1) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else udf_set = 1'b1;
        end
        if (rx_valid && exp_rr) rx_q.push_back(rx_data);
        if (wr && PADDR == 4'h3 && PWDATA[1]) rx_q.delete();
        m_ovf = ovf_set || (m_ovf && !(wr && PADDR == 4'h2 && PWDATA[4]));
        m_udf = udf_set || (m_udf && !(wr && PADDR == 4'h2 && PWDATA[5]));
        if (wr && PADDR == 4'h3) m_txen = PWDATA[2];
        m_irq = ((st_pre & m_mask) != 8'h00);
`ifdef APB2_FIFO_SLAVE_IRQ_EN
        if (wr && PADDR == 4'h6) m_mask = PWDATA;
`endif
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [7:0] d;
        int         phase;

        tbl[0]  = '{1'b0, 4'h2, 8'h00, 8'h0A};
        tbl[1]  = '{1'b0, 4'h4, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 4'h5, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 4'h0, 8'h11, 8'h00};
        tbl[4]  = '{1'b1, 4'h0, 8'h22, 8'h00};
        tbl[5]  = '{1'b1, 4'h0, 8'h33, 8'h00};
        tbl[6]  = '{1'b0, 4'h4, 8'h00, 8'h03};
        tbl[7]  = '{1'b0, 4'h2, 8'h00, 8'h08};
        tbl[8]  = '{1'b0, 4'h0, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 4'h7, 8'h00, 8'h00};
        tbl[10] = '{1'b0, 4'h6, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 4'hA, 8'h00, 8'h00};
        tbl[12] = '{1'b1, 4'h8, 8'h44, 8'h00};
        tbl[13] = '{1'b0, 4'h4, 8'h00, 8'h03};
        tbl[14] = '{1'b1, 4'h3, 8'h04, 8'h00};
        tbl[15] = '{1'b0, 4'h3, 8'h00, 8'h04};

        // Reset state
        #2;
        check8("rst_prdata", PRDATA, 8'h00);
        check1("rst_tx_valid", tx_valid, 1'b0);
        check1("rst_rx_ready", rx_ready, 1'b1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Register table
        foreach (tbl[i]) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else read_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
        end

        // TX drain on consecutive cycles
        tx_ready = 1'b1;
        #1 check1("drain_v0", tx_valid, 1'b1); check8("drain_d0", tx_data, 8'h11);
        @(negedge PCLK); #1 check8("drain_d1", tx_data, 8'h22);
        @(negedge PCLK); #1 check8("drain_d2", tx_data, 8'h33);
        @(negedge PCLK); #1 check1("drain_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;
        read_check("drain_cnt", 4'h4, 8'h00);

        // Write-to-valid latency
        apb_write(4'h0, 8'h77);
        #1 check1("lat_valid", tx_valid, 1'b1); check8("lat_data", tx_data, 8'h77);
        tx_ready = 1'b1;
        @(negedge PCLK); tx_ready = 1'b0;
        #1 check1("lat_popped", tx_valid, 1'b0);
        apb_write(4'h3, 8'h00);

        // TX overflow, W1C, flush
        for (int i = 0; i < 9; i++) apb_write(4'h0, 8'(8'h80 + i));
        read_check("ovf_cnt", 4'h4, 8'h08);
        read_check("ovf_status", 4'h2, 8'h19);
        apb_write(4'h2, 8'h10);
        read_check("ovf_clr", 4'h2, 8'h09);
        apb_write(4'h3, 8'h01);
        read_check("txflush_cnt", 4'h4, 8'h00);
        read_check("txflush_status", 4'h2, 8'h0A);
        read_check("ctrl_rd0", 4'h3, 8'h00);

        // RX stream in, pop, underflow
        rx_valid = 1'b1; rx_data = 8'hA5;
        #1 check1("rx_rdy", rx_ready, 1'b1);
        @(negedge PCLK); rx_data = 8'h5A;
        @(negedge PCLK); rx_valid = 1'b0;
        read_check("rx_cnt2", 4'h5, 8'h02);
        read_check("rx_pop0", 4'h1, 8'hA5);
        read_check("rx_pop1", 4'h1, 8'h5A);
        read_check("rx_pop_empty", 4'h1, 8'h00);
        read_check("udf_status", 4'h2, 8'h2A);
        apb_write(4'h2, 8'h20);
        read_check("udf_clr", 4'h2, 8'h0A);

        // RX fill, backpressure, flush
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'h40 + i);
            if (i == 8) begin
                #1 check1("rx_full_rdy", rx_ready, 1'b0);
            end
            @(negedge PCLK);
        end
        rx_valid = 1'b0;
        read_check("rx_fill_cnt", 4'h5, 8'h08);
        read_check("rx_fill_status", 4'h2, 8'h06);
        read_check("rx_fill_head", 4'h1, 8'h40);
        read_check("rx_fill_cnt7", 4'h5, 8'h07);
        apb_write(4'h3, 8'h02);
        read_check("rxflush_cnt", 4'h5, 8'h00);
        #1 check1("rxflush_rdy", rx_ready, 1'b1);

        // Async reset in the middle of an access
        for (int i = 1; i <= 3; i++) apb_write(4'h0, 8'(i));
        apb_write(4'h3, 8'h04);
        #1 check1("pre_rst_valid", tx_valid, 1'b1);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h4;
        #1 check8("pre_rst_cnt", PRDATA, 8'h03);
        @(negedge PCLK); PENABLE = 1'b1;
        #2 PRESETn = 1'b0;
        #1 check8("arst_prdata", PRDATA, 8'h00);
        check1("arst_tx_valid", tx_valid, 1'b0);
        check1("arst_rx_ready", rx_ready, 1'b1);
        @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        @(negedge PCLK);
        read_check("post_rst_cnt", 4'h4, 8'h00);
        read_check("post_rst_ctrl", 4'h3, 8'h00);
        read_check("post_rst_status", 4'h2, 8'h0A);

        // Randomized traffic against the model (DUT is in its reset-equivalent state here)
        m_ovf = 1'b0; m_udf = 1'b0; m_txen = 1'b0; m_irq = 1'b0; m_mask = 8'h00;
        tx_q.delete(); rx_q.delete();
        phase = 0;
        for (int n = 0; n < 3000; n++) begin
            if (phase == 1) begin
                PENABLE = 1'b1;
                phase   = 2;
            end else if ($urandom_range(0, 3) != 0) begin
                PSEL    = 1'b1;
                PENABLE = 1'b0;
                PWRITE  = 1'($urandom_range(0, 1));
                PADDR   = 4'($urandom_range(0, 9));
                PWDATA  = 8'($urandom);
                if (PWRITE && PADDR == 4'h3 && $urandom_range(0, 3) != 0) PWDATA[1:0] = 2'b00;
                phase   = 1;
            end else begin
                PSEL    = 1'b0;
                PENABLE = 1'b0;
                phase   = 0;
            end
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            #1 model_cycle();
            @(negedge PCLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
